mantissa_normalizer: RTL and testbench
======================================

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL have one clock and one reset: clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-high reset.
REQ-002 SHALL have the following upstream inputs from the complement adder stage:
- i_valid, input, 1, operand valid.
- i_sign, input, 1, result sign.
- i_exp, input, 8, common biased exponent.
- i_mant, input, 24, adder magnitude result.
- i_carry, input, 1, adder carry-out.
- i_shift_flag, input, 1, same-sign carry overflow.
REQ-003 SHALL drive o_ready, output, 1, high when a new operand can be accepted.
REQ-004 SHALL have downstream signals:
- i_ready, input, 1, downstream accepts the result.
- o_valid, output, 1, result valid.
- o_result, output, 32, packed IEEE-754 single.
- o_overflow, output, 1, result is infinity.
- o_underflow, output, 1, result was flushed to zero.
REQ-005 SHALL expose o_busy, output, 1, high while in state NORM.

Function
REQ-006 SHALL implement a 3-state FSM with states IDLE, NORM and OUT.
REQ-007 In IDLE, o_ready SHALL be 1; in NORM and OUT, o_ready SHALL be 0.
REQ-008 On i_valid&&o_ready, SHALL capture the operand into internal registers s, e (9-bit) and m (24-bit), then go to NORM.
REQ-009 At capture with i_shift_flag=1: m = {1'b1, i_mant[23:1]} and e = i_exp+1; otherwise m = i_mant and e = i_exp; i_carry is used only through i_shift_flag.
REQ-010 In NORM, one decision per cycle, in this priority order:
- (a) e>=255: load o_result={s,8'hFF,23'h0} and o_overflow=1.
- (b) m==0: load o_result=32'h00000000 with both flags 0.
- (c) m[23]=1: load o_result={s,e[7:0],m[22:0]}.
- (d) m[23]=0 and e<=1: load o_result={s,31'h0} and o_underflow=1.
- (e) otherwise: m = m<<1, e = e-1, stay in NORM.
REQ-011 Cases a–d SHALL go to OUT in the same edge that loads o_result.
REQ-012 Latency from the accept edge to o_valid=1 SHALL be 1+L cycles, where L is the number of shifts (0..23); the maximum is 24 cycles.
REQ-013 In OUT, o_valid SHALL be 1 and o_result, o_overflow and o_underflow SHALL stay stable until i_ready=1.
REQ-014 When i_ready=1 in OUT, SHALL go to IDLE at that edge and clear o_valid; a new operand SHALL NOT be accepted in the same cycle.
REQ-015 Rounding SHALL be truncation; denormals SHALL NOT be produced.
REQ-016 The shift count SHALL NOT exceed 23 per operation.

Reset
REQ-017 While rst=1, the FSM SHALL be in IDLE; o_valid, o_result, o_overflow, o_underflow and o_busy SHALL be 0; o_ready SHALL be 1.
REQ-018 Reset asserted in NORM or OUT SHALL abort the operation and discard the result; no o_valid pulse SHALL follow deassertion.

Structure
REQ-019 A shared package fp_pkg SHALL hold:
- the state enum (IDLE, NORM, OUT);
- EXP_W=8, MANT_W=24, EXP_MAX=8'hFF;
- the result field positions (sign 31, exponent 30:23, fraction 22:0).
REQ-020 No sub-module is required; the single-bit shift step and the packing SHALL be written inline.

Verification
REQ-021 Scenario, normalized input: i_mant=24'h800000, i_exp=8'h7F, s=0, flag=0 -> o_valid 1 cycle after accept, o_result=32'h3F800000, both flags 0.
REQ-022 Scenario, carry overflow (1.0+1.0): i_mant=24'h000000, i_carry=1, i_shift_flag=1, i_exp=8'h7F -> o_result=32'h40000000.
REQ-023 Scenario, maximum shift: i_mant=24'h000001, i_exp=8'h7F -> 23 shifts, o_valid 24 cycles after accept, o_result=32'h34000000, o_busy high for 24 cycles.
REQ-024 Overflow and underflow cases:
- Overflow: i_shift_flag=1, i_exp=8'hFE, s=1 -> o_result=32'hFF800000, o_overflow=1.
- Underflow: i_mant=24'h400000, i_exp=8'h01 -> o_result=32'h00000000, o_underflow=1.
REQ-025 Scenario, zero: i_mant=0, i_exp=8'h80, s=1, flag=0 -> o_result=32'h00000000, both flags 0.
REQ-026 Scenario, backpressure and reset: hold i_ready=0 for 3 cycles in OUT -> o_result unchanged and o_ready=0 throughout; assert rst during NORM of the REQ-023 case -> IDLE immediately, no o_valid afterward.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and field layout for the single-precision normalizer.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam int unsigned FRAC_LSB = 0;

endpackage

// File: rtl/mantissa_normalizer.sv
// Post-adder normalizer: shifts the magnitude left one bit per cycle until the
// hidden bit is set, then packs an IEEE-754 single with overflow/flush flags.
module mantissa_normalizer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_carry,
  input  logic              i_shift_flag,
  output logic              o_ready,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [31:0]       o_result,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_busy
);

  localparam logic [EXP_W:0] EXP_OVF  = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0] EXP_ONE  = 9'd1;

  state_t              r_state;
  logic                r_sign;
  logic [EXP_W:0]      r_exp;
  logic [MANT_W-1:0]   r_mant;
  logic [31:0]         r_result;
  logic                r_overflow;
  logic                r_underflow;

  // The carry-out is already folded into i_shift_flag by the adder stage.
  logic w_unused;
  assign w_unused = i_carry;

  // Control FSM: capture, one normalization decision per cycle, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= 9'd0;
      r_mant      <= 24'd0;
      r_result    <= 32'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_sign <= i_sign;
            if (i_shift_flag) begin
              r_mant <= {1'b1, i_mant[MANT_W-1:1]};
              r_exp  <= {1'b0, i_exp} + 9'd1;
            end else begin
              r_mant <= i_mant;
              r_exp  <= {1'b0, i_exp};
            end
            r_state <= NORM;
          end
        end
        NORM: begin
          if (r_exp >= EXP_OVF) begin
            r_result[SIGN_BIT]          <= r_sign;
            r_result[EXP_MSB:EXP_LSB]   <= EXP_MAX;
            r_result[FRAC_MSB:FRAC_LSB] <= 23'd0;
            r_overflow  <= 1'b1;
            r_underflow <= 1'b0;
            r_state     <= OUT;
          end else if (r_mant == 24'd0) begin
            r_result    <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= OUT;
          end else if (r_mant[MANT_W-1]) begin
            r_result[SIGN_BIT]          <= r_sign;
            r_result[EXP_MSB:EXP_LSB]   <= r_exp[EXP_W-1:0];
            r_result[FRAC_MSB:FRAC_LSB] <= r_mant[MANT_W-2:0];
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= OUT;
          end else if (r_exp <= EXP_ONE) begin
            // No denormals: anything that cannot reach the hidden bit flushes to signed zero.
            r_result[SIGN_BIT]          <= r_sign;
            r_result[EXP_MSB:EXP_LSB]   <= 8'd0;
            r_result[FRAC_MSB:FRAC_LSB] <= 23'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b1;
            r_state     <= OUT;
          end else begin
            r_mant <= {r_mant[MANT_W-2:0], 1'b0};
            r_exp  <= r_exp - 9'd1;
          end
        end
        OUT: begin
          if (i_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_busy      = (r_state == NORM);
  assign o_valid     = (r_state == OUT);
  assign o_result    = r_result;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Scoreboard bench: a driver pushes model expectations, a monitor pops and
// compares whenever the normalizer presents a result.
module tb_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_sign, i_carry, i_shift_flag, i_ready;
  logic [7:0]  i_exp;
  logic [23:0] i_mant;
  logic        o_ready, o_valid, o_overflow, o_underflow, o_busy;
  logic [31:0] o_result;

  mantissa_normalizer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sign(i_sign), .i_exp(i_exp),
    .i_mant(i_mant), .i_carry(i_carry), .i_shift_flag(i_shift_flag),
    .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid), .o_result(o_result),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value-level description of the normalization outcome.
  function automatic exp_t model(input logic s, input logic [7:0] ex, input logic [23:0] mant,
                                 input logic flag);
    exp_t r;
    int e, lead, lz, j;
    logic [23:0] m, mm;
    r.res = 32'd0; r.ovf = 1'b0; r.unf = 1'b0; r.lat = 1; r.acc = 0; r.hold = 0;
    if (flag) begin
      m = {1'b1, mant[23:1]};
      e = int'(ex) + 1;
    end else begin
      m = mant;
      e = int'(ex);
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else if (m == 24'd0) begin
      r.res = 32'd0;
    end else begin
      lead = 0;
      for (int i = 0; i < 24; i++) if (m[i]) lead = i;
      lz = 23 - lead;
      if (lz == 0 || e >= lz + 1) begin
        mm = m << lz;
        r.res = {s, 8'(e - lz), mm[22:0]};
        r.lat = 1 + lz;
      end else begin
        j = (e <= 1) ? 0 : e - 1;
        r.res = {s, 31'd0};
        r.unf = 1'b1;
        r.lat = 1 + j;
      end
    end
    return r;
  endfunction

  // Presents one operand, waits for acceptance, and records the expectation.
  task automatic send(input logic s, input logic [7:0] ex, input logic [23:0] mant,
                      input logic carry, input logic flag, input int hold);
    exp_t e;
    int waited;
    @(negedge clk);
    i_valid = 1'b1; i_sign = s; i_exp = ex; i_mant = mant;
    i_carry = carry; i_shift_flag = flag;
    waited = 0;
    while (!o_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: actual=ready_low required=ready_high");
    end
    e = model(s, ex, mant, flag);
    e.acc = cyc + 1;
    e.hold = hold;
    q.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_mant = 24'($urandom);
    i_exp = 8'($urandom);
  endtask

  // Monitor: compares each presented result and exercises backpressure.
  initial begin
    exp_t e;
    logic [31:0] held;
    i_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: actual=valid required=no_valid (cycle %0d)", cyc);
          i_ready = 1'b1;
          @(negedge clk);
          i_ready = 1'b0;
        end else begin
          e = q.pop_front();
          check("result", o_result, e.res);
          check("overflow", {31'd0, o_overflow}, {31'd0, e.ovf});
          check("underflow", {31'd0, o_underflow}, {31'd0, e.unf});
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          held = o_result;
          for (int k = 0; k < e.hold; k++) begin
            i_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            check("hold_result", o_result, held);
            check("hold_ready", {31'd0, o_ready}, 32'd0);
          end
          i_ready = 1'b1;
          @(negedge clk);
          i_ready = 1'b0;
          check("release_valid", {31'd0, o_valid}, 32'd0);
          check("release_ready", {31'd0, o_ready}, 32'd1);
        end
      end
    end
  end

  initial begin
    int busy_cnt, vcnt, waited;
    logic [7:0] ex;
    logic [23:0] m;
    rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_exp = 8'd0; i_mant = 24'd0;
    i_carry = 1'b0; i_shift_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_flags", {30'd0, o_overflow, o_underflow}, 32'd0);
    rst = 1'b0;

    // Directed scenarios
    send(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 0);
    check("dir_norm_model", q[q.size()-1].res, 32'h3F800000);
    send(1'b0, 8'h7F, 24'h000000, 1'b1, 1'b1, 0);
    check("dir_carry_model", q[q.size()-1].res, 32'h40000000);
    send(1'b1, 8'hFE, 24'h123456, 1'b1, 1'b1, 0);
    check("dir_ovf_model", q[q.size()-1].res, 32'hFF800000);
    send(1'b0, 8'h01, 24'h400000, 1'b0, 1'b0, 0);
    send(1'b1, 8'h80, 24'h000000, 1'b0, 1'b0, 0);
    send(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 3);

    // Maximum shift with busy duration
    send(1'b0, 8'h7F, 24'h000001, 1'b0, 1'b0, 0);
    check("dir_maxshift_model", q[q.size()-1].res, 32'h34000000);
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
      if (o_valid) break;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd24);

    // Reset in the middle of NORM discards the operation
    repeat (3) @(negedge clk);
    send(1'b0, 8'h7F, 24'h000001, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_abort_busy", {31'd0, o_busy}, 32'd0);
    check("rst_abort_ready", {31'd0, o_ready}, 32'd1);
    check("rst_abort_valid", {31'd0, o_valid}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    check("no_valid_after_rst", 32'(vcnt), 32'd0);

    // Randomized operands
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: ex = 8'($urandom_range(0, 30));
        1: ex = 8'($urandom_range(245, 255));
        default: ex = 8'($urandom);
      endcase
      m = 24'($urandom) >> $urandom_range(0, 24);
      send(1'($urandom), ex, m, 1'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    end

    waited = 0;
    while (q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
